// File: rtl/alu_issue_stage_if.sv
// Handshake and payload bundle between the upstream fetch/regfile side,
// the alu_issue_stage slot, and the downstream ALU/EX consumer.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [4:0]  rd;
  logic        illegal;

  // Environment side: drives instructions in and consumes decoded slots.
  modport master (
    output in_valid, instr, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_control, operand1, operand2, rd, illegal
  );

  // Issue stage side.
  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_control, operand1, operand2, rd, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP / OP-IMM decode and issue stage feeding the alu block.
// Decodes into an ALU control code plus operands and holds the result in a
// single registered valid/ready slot; illegal encodings are flagged and counted.
module alu_issue_stage (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus,
  output logic [7:0]         illegal_count
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        unused_rs1_field;

  logic [3:0]  dec_alu;
  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  logic [4:0]  dec_rd;
  logic        dec_illegal;

  logic        out_valid_q, out_valid_d;
  logic [3:0]  alu_control_q, alu_control_d;
  logic [31:0] operand1_q, operand1_d;
  logic [31:0] operand2_q, operand2_d;
  logic [4:0]  rd_q, rd_d;
  logic        illegal_q, illegal_d;
  logic [7:0]  illegal_count_q, illegal_count_d;

  logic        accept;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  // The rs1 register index is resolved upstream; only its data arrives here.
  assign unused_rs1_field = ^bus.instr[19:15];

  // funct3 map shared by OP (funct7 = 0) and OP-IMM.
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  // Decode the presented instruction; illegal encodings collapse to a harmless ADD of zeros.
  always_comb begin
    dec_illegal = 1'b0;
    dec_alu     = ALU_ADD;
    dec_op1     = bus.rs1_data;
    dec_op2     = bus.rs2_data;
    dec_rd      = bus.instr[11:7];
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec_alu = base_alu(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_alu = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_alu = ALU_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_alu = base_alu(funct3);
        dec_op2 = {{20{bus.instr[31]}}, bus.instr[31:20]};
        if (funct3 == 3'b001) begin
          dec_op2 = {27'b0, bus.instr[24:20]};
          if (funct7 != F7_BASE) dec_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec_op2 = {27'b0, bus.instr[24:20]};
          if (funct7 == F7_ALT) begin
            dec_alu = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            dec_illegal = 1'b1;
          end
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_alu = ALU_ADD;
      dec_op1 = 32'd0;
      dec_op2 = 32'd0;
      dec_rd  = 5'd0;
    end
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Slot next-state: load on accept, drop valid on a bare consume, otherwise hold.
  always_comb begin
    out_valid_d     = out_valid_q;
    alu_control_d   = alu_control_q;
    operand1_d      = operand1_q;
    operand2_d      = operand2_q;
    rd_d            = rd_q;
    illegal_d       = illegal_q;
    illegal_count_d = illegal_count_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      alu_control_d = dec_alu;
      operand1_d    = dec_op1;
      operand2_d    = dec_op2;
      rd_d          = dec_rd;
      illegal_d     = dec_illegal;
      if (dec_illegal && illegal_count_q != 8'hFF) begin
        illegal_count_d = illegal_count_q + 8'd1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Slot registers; reset clears everything so no held op survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      alu_control_q   <= 4'd0;
      operand1_q      <= 32'd0;
      operand2_q      <= 32'd0;
      rd_q            <= 5'd0;
      illegal_q       <= 1'b0;
      illegal_count_q <= 8'd0;
    end else begin
      out_valid_q     <= out_valid_d;
      alu_control_q   <= alu_control_d;
      operand1_q      <= operand1_d;
      operand2_q      <= operand2_d;
      rd_q            <= rd_d;
      illegal_q       <= illegal_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.alu_control = alu_control_q;
  assign bus.operand1    = operand1_q;
  assign bus.operand2    = operand2_q;
  assign bus.rd          = rd_q;
  assign bus.illegal     = illegal_q;
  assign illegal_count   = illegal_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode cases, back-to-back issue,
// stall hold, illegal flagging with saturating count, and async reset.
module tb_alu_issue_stage;

  logic       clk;
  logic       rst_n;
  logic [7:0] illegal_count;
  int         total;
  int         bad;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of upstream/downstream inputs.
  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic ordy);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.rs1_data  = r1;
    bus.rs2_data  = r2;
    bus.out_ready = ordy;
  endtask

  // One comparison; counts every check and every failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the full registered slot against expected values.
  task automatic checkSlot(input string tag, input logic v, input logic [3:0] alu,
                           input logic [31:0] o1, input logic [31:0] o2,
                           input logic [4:0] r, input logic ill);
    checkOutput({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    checkOutput({tag, ".alu_control"}, {28'd0, bus.alu_control}, {28'd0, alu});
    checkOutput({tag, ".operand1"}, bus.operand1, o1);
    checkOutput({tag, ".operand2"}, bus.operand2, o2);
    checkOutput({tag, ".rd"}, {27'd0, bus.rd}, {27'd0, r});
    checkOutput({tag, ".illegal"}, {31'd0, bus.illegal}, {31'd0, ill});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    #1 rst_n = 1'b0;
    #2;
    checkSlot("reset", 1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    checkOutput("reset.count", {24'd0, illegal_count}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    checkOutput("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);

    // ADD x3,x1,x2
    applyStimulus(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1);
    step();
    checkSlot("add", 1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b0);

    // SUB x5,x6,x7 then ADDI x1,x0,-1 back to back
    applyStimulus(1'b1, 32'h407302B3, 32'd10, 32'd3, 1'b1);
    step();
    checkSlot("sub", 1'b1, 4'b0110, 32'd10, 32'd3, 5'd5, 1'b0);
    checkOutput("sub.in_ready", {31'd0, bus.in_ready}, 32'd1);
    applyStimulus(1'b1, 32'hFFF00093, 32'd0, 32'd123, 1'b1);
    step();
    checkSlot("addi", 1'b1, 4'b0010, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b0);
    checkOutput("addi.in_ready", {31'd0, bus.in_ready}, 32'd1);

    // SRAI x2,x2,4
    applyStimulus(1'b1, 32'h40415113, 32'h80000000, 32'h0000DEAD, 1'b1);
    step();
    checkSlot("srai", 1'b1, 4'b0101, 32'h80000000, 32'h00000004, 5'd2, 1'b0);

    // XOR x4,x1,x2 accepted, then stall three cycles with OR x6,x1,x2 waiting
    applyStimulus(1'b1, 32'h0020C233, 32'h00000F0F, 32'h000000FF, 1'b1);
    step();
    checkSlot("xor", 1'b1, 4'b1001, 32'h00000F0F, 32'h000000FF, 5'd4, 1'b0);
    applyStimulus(1'b1, 32'h0020E333, 32'h00001111, 32'h00002222, 1'b0);
    #1;
    checkOutput("stall.in_ready0", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkSlot("stall", 1'b1, 4'b1001, 32'h00000F0F, 32'h000000FF, 5'd4, 1'b0);
      checkOutput("stall.in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("release.in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    checkSlot("or", 1'b1, 4'b0001, 32'h00001111, 32'h00002222, 5'd6, 1'b0);

    // Illegal opcode and illegal funct7/funct3 combination
    applyStimulus(1'b1, 32'h00000000, 32'd9, 32'd9, 1'b1);
    step();
    checkSlot("ill0", 1'b1, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b1);
    checkOutput("ill0.count", {24'd0, illegal_count}, 32'd1);
    applyStimulus(1'b1, 32'h4020C1B3, 32'd5, 32'd6, 1'b1);
    step();
    checkSlot("ill1", 1'b1, 4'b0010, 32'd0, 32'd0, 5'd0, 1'b1);
    checkOutput("ill1.count", {24'd0, illegal_count}, 32'd2);

    // Bare consume empties the slot
    applyStimulus(1'b0, 32'h002081B3, 32'd1, 32'd1, 1'b1);
    step();
    checkOutput("drain.out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("drain.count", {24'd0, illegal_count}, 32'd2);

    // Saturation: 300 illegal accepts in total
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 253; i++) step();
    checkOutput("sat255.count", {24'd0, illegal_count}, 32'd255);
    for (int i = 0; i < 45; i++) step();
    checkOutput("sat300.count", {24'd0, illegal_count}, 32'd255);

    // Reset during a stall drops the held op immediately
    applyStimulus(1'b1, 32'h002081B3, 32'd5, 32'd7, 1'b1);
    step();
    applyStimulus(1'b1, 32'h407302B3, 32'd1, 32'd2, 1'b0);
    step();
    checkSlot("prerst", 1'b1, 4'b0010, 32'd5, 32'd7, 5'd3, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checkSlot("midrst", 1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0);
    checkOutput("midrst.count", {24'd0, illegal_count}, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("postrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    checkOutput("postrst.out_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
